// File: rtl/cart_bus_pkg.sv
// Shared definitions for the cartridge-slot bridge: FSM encodings, read-data default
// and the default address window.
package cart_bus_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_RDWAIT = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [7:0]  RDATA_DEFAULT     = 8'hFF;
    localparam logic [15:0] DEFAULT_ADDR_BASE = 16'h0000;
    localparam logic [15:0] DEFAULT_ADDR_MASK = 16'hC000;

    function automatic logic addr_hit(input logic [15:0] addr, input logic [15:0] base,
                                      input logic [15:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/cart_sync_ff.sv
// Multi-stage synchronizer for one asynchronous active-low slot strobe.
// Resets to 1 so a strobe reads as inactive until genuinely sampled low.
module cart_sync_ff #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic synced
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], raw};
        end
    end

    assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/cart_slot_bridge.sv
// Turns asynchronous MSX slot strobes into one valid/ready bus transaction per access,
// holding the CPU in WAIT_n until the internal side has finished.
module cart_slot_bridge
    import cart_bus_pkg::*;
#(
    parameter logic [15:0] ADDR_BASE     = DEFAULT_ADDR_BASE,
    parameter logic [15:0] ADDR_MASK     = DEFAULT_ADDR_MASK,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned RDATA_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_slot_sltsl_n,
    input  logic        p_slot_rd_n,
    input  logic        p_slot_wr_n,
    input  logic [15:0] p_slot_address,
    input  logic [7:0]  p_slot_wdata,
    output logic [7:0]  p_slot_rdata,
    output logic        p_slot_data_en,
    output logic        p_slot_wait_n,
    output logic [15:0] bus_address,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_write,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_rdata_en
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(RDATA_TIMEOUT);

    logic       sltsl_s, rd_s, wr_s;
    logic       sel, rd, wr;
    logic [1:0] state;
    logic [7:0] cnt;
    logic [7:0] cnt_next;

    cart_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sltsl (
        .clk    (clk),
        .reset  (reset),
        .raw    (p_slot_sltsl_n),
        .synced (sltsl_s)
    );

    cart_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rd (
        .clk    (clk),
        .reset  (reset),
        .raw    (p_slot_rd_n),
        .synced (rd_s)
    );

    cart_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (
        .clk    (clk),
        .reset  (reset),
        .raw    (p_slot_wr_n),
        .synced (wr_s)
    );

    // RD and WR low together is treated as neither.
    assign sel      = !sltsl_s;
    assign rd       = sel && !rd_s && wr_s;
    assign wr       = sel && !wr_s && rd_s;
    assign cnt_next = cnt + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= 8'd0;
            bus_valid      <= 1'b0;
            bus_write      <= 1'b0;
            bus_address    <= 16'h0000;
            bus_wdata      <= 8'h00;
            p_slot_rdata   <= 8'h00;
            p_slot_data_en <= 1'b0;
            p_slot_wait_n  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((rd || wr) && addr_hit(p_slot_address, ADDR_BASE, ADDR_MASK)) begin
                        bus_address   <= p_slot_address;
                        bus_write     <= wr;
                        bus_wdata     <= p_slot_wdata;
                        bus_valid     <= 1'b1;
                        p_slot_wait_n <= 1'b0;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Strobe withdrawal is deliberately ignored; the request must complete.
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        cnt       <= 8'd0;
                        state     <= bus_write ? ST_HOLD : ST_RDWAIT;
                    end
                end
                ST_RDWAIT: begin
                    if (bus_rdata_en) begin
                        p_slot_rdata <= bus_rdata;
                        state        <= ST_HOLD;
                    end else if (cnt_next == TIMEOUT_LIM) begin
                        p_slot_rdata <= RDATA_DEFAULT;
                        state        <= ST_HOLD;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                ST_HOLD: begin
                    p_slot_wait_n <= 1'b1;
                    // Leaving only on full release keeps the same access from re-triggering.
                    if (!sel && !rd && !wr) begin
                        p_slot_data_en <= 1'b0;
                        state          <= ST_IDLE;
                    end else begin
                        p_slot_data_en <= !bus_write && rd;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cart_slot_bridge.sv
// Directed bench for cart_slot_bridge with a simple valid/ready target model.
module tb_cart_slot_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_slot_sltsl_n, p_slot_rd_n, p_slot_wr_n;
    logic [15:0] p_slot_address;
    logic [7:0]  p_slot_wdata;
    logic [7:0]  p_slot_rdata;
    logic        p_slot_data_en, p_slot_wait_n;
    logic [15:0] bus_address;
    logic        bus_valid, bus_ready, bus_write;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'h00;
    logic        bus_rdata_en = 1'b0;

    logic       tgt_en;
    logic [7:0] tgt_data;
    int         checks = 0;
    int         errors = 0;
    int         accepts = 0;
    int         a0;

    cart_slot_bridge dut (
        .clk            (clk),
        .reset          (reset),
        .p_slot_sltsl_n (p_slot_sltsl_n),
        .p_slot_rd_n    (p_slot_rd_n),
        .p_slot_wr_n    (p_slot_wr_n),
        .p_slot_address (p_slot_address),
        .p_slot_wdata   (p_slot_wdata),
        .p_slot_rdata   (p_slot_rdata),
        .p_slot_data_en (p_slot_data_en),
        .p_slot_wait_n  (p_slot_wait_n),
        .bus_address    (bus_address),
        .bus_valid      (bus_valid),
        .bus_ready      (bus_ready),
        .bus_write      (bus_write),
        .bus_wdata      (bus_wdata),
        .bus_rdata      (bus_rdata),
        .bus_rdata_en   (bus_rdata_en)
    );

    always #5 clk = ~clk;

    // Target: counts accepts, returns read data one cycle after accept when enabled.
    always @(posedge clk) begin
        if (bus_valid && bus_ready) accepts++;
        bus_rdata_en <= bus_valid && bus_ready && !bus_write && tgt_en;
        if (bus_valid && bus_ready && !bus_write) bus_rdata <= tgt_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic release_slot();
        p_slot_sltsl_n = 1'b1;
        p_slot_rd_n    = 1'b1;
        p_slot_wr_n    = 1'b1;
    endtask

    task automatic start_access(input logic is_wr, input logic is_rd, input logic [15:0] addr,
                                input logic [7:0] data);
        p_slot_address = addr;
        p_slot_wdata   = data;
        p_slot_sltsl_n = 1'b0;
        p_slot_wr_n    = !is_wr;
        p_slot_rd_n    = !is_rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        release_slot();
        p_slot_address = 16'h0000;
        p_slot_wdata   = 8'h00;
        bus_ready      = 1'b1;
        tgt_en         = 1'b1;
        tgt_data       = 8'h00;

        #2;
        chk("rst_valid", 16'(bus_valid), 16'd0);
        chk("rst_wait_n", 16'(p_slot_wait_n), 16'd1);
        chk("rst_data_en", 16'(p_slot_data_en), 16'd0);
        chk("rst_rdata", 16'(p_slot_rdata), 16'h0000);
        chk("rst_addr", bus_address, 16'h0000);
        ticks(2);
        reset = 1'b0;
        ticks(3);

        // Write 3FFFh = 5Ah, zero-wait target
        a0 = accepts;
        start_access(1'b1, 1'b0, 16'h3FFF, 8'h5A);
        tick();
        chk("wr_valid_c1", 16'(bus_valid), 16'd0);
        tick();
        chk("wr_valid_c2", 16'(bus_valid), 16'd0);
        tick();
        chk("wr_valid_c3", 16'(bus_valid), 16'd1);
        chk("wr_write", 16'(bus_write), 16'd1);
        chk("wr_addr", bus_address, 16'h3FFF);
        chk("wr_wdata", 16'(bus_wdata), 16'h005A);
        chk("wr_wait_low", 16'(p_slot_wait_n), 16'd0);
        tick();
        chk("wr_valid_drop", 16'(bus_valid), 16'd0);
        chk("wr_wait_still_low", 16'(p_slot_wait_n), 16'd0);
        tick();
        chk("wr_wait_high", 16'(p_slot_wait_n), 16'd1);
        chk("wr_no_data_en", 16'(p_slot_data_en), 16'd0);
        tick();
        chk("wr_hold_no_data_en", 16'(p_slot_data_en), 16'd0);
        release_slot();
        ticks(4);
        chk("wr_one_accept", 16'(accepts - a0), 16'd1);
        chk("wr_idle_wait_n", 16'(p_slot_wait_n), 16'd1);

        // Read 1234h, target returns A5h one cycle after accept
        a0 = accepts;
        tgt_data = 8'hA5;
        start_access(1'b0, 1'b1, 16'h1234, 8'h00);
        ticks(3);
        chk("rd_valid", 16'(bus_valid), 16'd1);
        chk("rd_write", 16'(bus_write), 16'd0);
        chk("rd_addr", bus_address, 16'h1234);
        chk("rd_wait_low", 16'(p_slot_wait_n), 16'd0);
        tick();
        chk("rd_valid_drop", 16'(bus_valid), 16'd0);
        tick();
        chk("rd_wait_low_c5", 16'(p_slot_wait_n), 16'd0);
        chk("rd_data_en_c5", 16'(p_slot_data_en), 16'd0);
        tick();
        chk("rd_data_en", 16'(p_slot_data_en), 16'd1);
        chk("rd_wait_high", 16'(p_slot_wait_n), 16'd1);
        chk("rd_rdata", 16'(p_slot_rdata), 16'h00A5);
        release_slot();
        ticks(2);
        chk("rd_data_en_hold", 16'(p_slot_data_en), 16'd1);
        tick();
        chk("rd_data_en_off", 16'(p_slot_data_en), 16'd0);
        chk("rd_one_accept", 16'(accepts - a0), 16'd1);
        ticks(2);

        // Read 0010h with bus_ready low for 5 cycles
        a0 = accepts;
        bus_ready = 1'b0;
        tgt_data = 8'h3C;
        start_access(1'b0, 1'b1, 16'h0010, 8'h00);
        ticks(3);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 16'(bus_valid), 16'd1);
            chk("stall_addr", bus_address, 16'h0010);
            chk("stall_wait_low", 16'(p_slot_wait_n), 16'd0);
            if (i < 4) tick();
        end
        chk("stall_no_accept", 16'(accepts - a0), 16'd0);
        bus_ready = 1'b1;
        tick();
        chk("stall_valid_drop", 16'(bus_valid), 16'd0);
        ticks(2);
        chk("stall_data_en", 16'(p_slot_data_en), 16'd1);
        chk("stall_wait_high", 16'(p_slot_wait_n), 16'd1);
        chk("stall_rdata", 16'(p_slot_rdata), 16'h003C);
        chk("stall_one_accept", 16'(accepts - a0), 16'd1);
        release_slot();
        ticks(5);

        // Read 2000h with no read data: timeout returns FFh
        tgt_en = 1'b0;
        start_access(1'b0, 1'b1, 16'h2000, 8'h00);
        ticks(3);
        chk("to_valid", 16'(bus_valid), 16'd1);
        tick();
        ticks(14);
        chk("to_wait_low_early", 16'(p_slot_wait_n), 16'd0);
        chk("to_rdata_early", 16'(p_slot_rdata), 16'h003C);
        tick();
        chk("to_rdata_ff", 16'(p_slot_rdata), 16'h00FF);
        chk("to_wait_low_latch", 16'(p_slot_wait_n), 16'd0);
        tick();
        chk("to_wait_high", 16'(p_slot_wait_n), 16'd1);
        chk("to_data_en", 16'(p_slot_data_en), 16'd1);
        release_slot();
        ticks(5);
        tgt_en = 1'b1;

        // Window miss at 4000h, then RD_n and WR_n both low
        a0 = accepts;
        start_access(1'b0, 1'b1, 16'h4000, 8'h00);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("miss_valid", 16'(bus_valid), 16'd0);
            chk("miss_wait_n", 16'(p_slot_wait_n), 16'd1);
            chk("miss_data_en", 16'(p_slot_data_en), 16'd0);
        end
        release_slot();
        ticks(4);
        start_access(1'b1, 1'b1, 16'h0100, 8'h99);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("illegal_valid", 16'(bus_valid), 16'd0);
            chk("illegal_wait_n", 16'(p_slot_wait_n), 16'd1);
            chk("illegal_data_en", 16'(p_slot_data_en), 16'd0);
        end
        release_slot();
        ticks(4);
        chk("miss_no_accept", 16'(accepts - a0), 16'd0);

        // Reset during REQ
        bus_ready = 1'b0;
        start_access(1'b1, 1'b0, 16'h0200, 8'h11);
        ticks(3);
        chk("rreq_valid_pre", 16'(bus_valid), 16'd1);
        #2 reset = 1'b1;
        #1;
        chk("rreq_valid", 16'(bus_valid), 16'd0);
        chk("rreq_addr", bus_address, 16'h0000);
        chk("rreq_wdata", 16'(bus_wdata), 16'h0000);
        chk("rreq_write", 16'(bus_write), 16'd0);
        chk("rreq_wait_n", 16'(p_slot_wait_n), 16'd1);
        release_slot();
        bus_ready = 1'b1;
        ticks(3);
        reset = 1'b0;
        ticks(3);

        // Reset during HOLD of a read
        tgt_data = 8'hA5;
        start_access(1'b0, 1'b1, 16'h1234, 8'h00);
        ticks(6);
        chk("rhold_data_en_pre", 16'(p_slot_data_en), 16'd1);
        #2 reset = 1'b1;
        #1;
        chk("rhold_data_en", 16'(p_slot_data_en), 16'd0);
        chk("rhold_rdata", 16'(p_slot_rdata), 16'h0000);
        chk("rhold_addr", bus_address, 16'h0000);
        chk("rhold_wait_n", 16'(p_slot_wait_n), 16'd1);
        release_slot();
        ticks(3);
        reset = 1'b0;
        ticks(3);

        // Write 0000h = 77h after reset completes normally
        a0 = accepts;
        start_access(1'b1, 1'b0, 16'h0000, 8'h77);
        ticks(3);
        chk("post_valid", 16'(bus_valid), 16'd1);
        chk("post_write", 16'(bus_write), 16'd1);
        chk("post_addr", bus_address, 16'h0000);
        chk("post_wdata", 16'(bus_wdata), 16'h0077);
        chk("post_wait_low", 16'(p_slot_wait_n), 16'd0);
        ticks(2);
        chk("post_wait_high", 16'(p_slot_wait_n), 16'd1);
        release_slot();
        ticks(4);
        chk("post_one_accept", 16'(accepts - a0), 16'd1);
        chk("post_data_en", 16'(p_slot_data_en), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cart_slot_bridge.md
Name: cart_slot_bridge

Overview:
- Upstream stage for the internal memory-bus targets (16 KB RAM at 0000h-3FFFh and similar valid/ready targets).
- Converts asynchronous MSX cartridge-slot strobes (SLTSL_n, RD_n, WR_n, A[15:0], D[7:0]) into single internal bus transactions.
- Returns read data from bus_rdata/bus_rdata_en to the slot data bus.
- Holds the Z80 in WAIT_n until the internal side has completed.

Parameters:
ADDR_BASE, 16'h0000, window base; a slot access is claimed when (address & ADDR_MASK) == ADDR_BASE
ADDR_MASK, 16'hC000, window mask (default gives 0000h-3FFFh)
SYNC_STAGES, 2, flip-flop stages on each slot strobe (legal range 2-3)
RDATA_TIMEOUT, 15, cycles to wait for bus_rdata_en before returning 8'hFF (legal range 1-255)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
p_slot_sltsl_n  in  1  slot select, asynchronous
p_slot_rd_n  in  1  read strobe, asynchronous
p_slot_wr_n  in  1  write strobe, asynchronous
p_slot_address  in  16  slot address, stable while strobe active
p_slot_wdata  in  8  slot data bus input
p_slot_rdata  out  8  data to drive onto slot bus
p_slot_data_en  out  1  1 = drive p_slot_rdata onto slot bus
p_slot_wait_n  out  1  0 = hold CPU in wait
bus_address  out  16  internal address (consumers truncate)
bus_valid  out  1  request
bus_ready  in  1  target accepts when bus_valid and bus_ready
bus_write  out  1  1 = write, 0 = read
bus_wdata  out  8  write data
bus_rdata  in  8  read data
bus_rdata_en  in  1  read data qualifier, one-cycle pulse

Behaviour:
- Reset (asynchronous, immediate, including mid-transaction):
  - State IDLE.
  - bus_valid=0, bus_write=0, bus_address=0, bus_wdata=0.
  - p_slot_rdata=0, p_slot_data_en=0, p_slot_wait_n=1.
  - Synchronizers set to 1 (inactive).
  - Timeout counter = 0.
- Strobe synchronization:
  - sltsl_n, rd_n and wr_n each pass through SYNC_STAGES flip-flops.
  - Address and wdata are sampled raw at the capture cycle; they are stable by then.
  - sel = !sltsl_s; rd = sel && !rd_s && wr_s; wr = sel && !wr_s && rd_s.
  - rd and wr both low is illegal: ignored, stay IDLE.
- IDLE:
  - If (rd or wr) and the address hits the window: capture address, write flag and wdata; bus_valid=1; wait_n=0; go to REQ.
  - A miss or illegal strobe is never claimed: data_en stays 0, wait_n stays 1, and the state remains IDLE until the strobes release.
- REQ:
  - Hold bus_valid, address, write and wdata constant until bus_ready.
  - On the accept cycle: bus_valid=0 next cycle. Writes go to HOLD. Reads go to RDWAIT with counter cleared.
  - Withdrawal of the slot strobe does not abort REQ.
- RDWAIT:
  - bus_rdata_en=1: latch bus_rdata into p_slot_rdata and go to HOLD.
  - Otherwise increment the counter. When counter == RDATA_TIMEOUT: latch 8'hFF and go to HOLD.
  - bus_rdata_en outside RDWAIT is ignored.
- HOLD:
  - wait_n=1.
  - data_en=1 only for reads while the synchronized rd is still active.
  - When sel, rd and wr are all inactive: data_en=0, go to IDLE. The IDLE rule prevents re-triggering the same access.
  - If the strobe was already withdrawn, HOLD lasts one cycle with data_en=0.
- Latency (zero-wait target, ready=1, rdata_en one cycle after accept):
  - Write: strobe edge to bus_valid = SYNC_STAGES+1 cycles; wait_n released 2 cycles after bus_valid.
  - Read: data_en and wait_n=1 appear 3 cycles after bus_valid rises.
- Exactly one internal transaction per slot strobe assertion.

Decomposition:
- Shared package cart_bus_pkg:
  - State enum (IDLE, REQ, RDWAIT, HOLD).
  - Constant RDATA_DEFAULT = 8'hFF.
  - Default window constants.
- One natural sub-module, cart_sync_ff: parameterized SYNC_STAGES synchronizer with reset value 1, instantiated three times.

Test Plan:
- Write 3FFFh=5Ah, bus_ready=1 → exactly one bus_valid pulse with bus_write=1, bus_address=3FFFh, bus_wdata=5Ah; wait_n low then high before WR_n release; no data_en.
- Read 1234h, target returns A5h one cycle after accept → p_slot_rdata=A5h with data_en=1 until RD_n rises, then data_en=0 and state IDLE.
- Read with bus_ready low for 5 cycles → bus_valid and bus_address held stable for all 5 cycles, single accept, correct data returned.
- Read with bus_rdata_en never asserted → after 15 RDWAIT cycles p_slot_rdata=FFh, data_en=1, wait_n=1.
- Access at 4000h, and access with RD_n and WR_n both low → no bus_valid, data_en=0, wait_n=1 throughout.
- Reset asserted in REQ and in HOLD → all outputs return to reset values immediately; a subsequent write at 0000h completes normally.
